// File: rtl/switch_debounce_pkg.sv
// Shared constants and width helper for the switch debounce block.
package switch_debounce_pkg;

  localparam int DEB_TICK_50MHZ_20MS = 1_000_000;
  localparam int DEB_STABLE_SAMPLES  = 3;

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/switch_debounce_bit.sv
// One switch line: 2-flop synchroniser, agreement counter, committed level and sticky event.
module switch_debounce_bit
  import switch_debounce_pkg::*;
#(
  parameter int STABLE_SAMPLES = DEB_STABLE_SAMPLES,
  parameter int CNT_W          = clog2(STABLE_SAMPLES) + 1
) (
  input  logic iClk,
  input  logic iRst,
  input  logic i_raw,
  input  logic i_tick,
  input  logic i_ack,
  output logic o_level,
  output logic o_event
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_SAMPLES - 1);

  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_event;
  logic             w_differ;
  logic             w_commit;

  assign w_differ = (r_sync[1] != r_level);
  assign w_commit = i_tick && w_differ && (r_cnt == CNT_LAST);

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_sync  <= 2'b00;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_event <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_raw};
      if (i_tick) begin
        if (!w_differ) begin
          r_cnt <= '0;
        end else if (w_commit) begin
          r_cnt   <= '0;
          r_level <= r_sync[1];
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
      // A commit on the same cycle as an ack must stay visible.
      if (w_commit) begin
        r_event <= 1'b1;
      end else if (i_ack) begin
        r_event <= 1'b0;
      end
    end
  end

  assign o_level = r_level;
  assign o_event = r_event;

endmodule

// File: rtl/switch_debounce.sv
// Debounces WIDTH asynchronous switch lines on a shared slow sample tick.
module switch_debounce
  import switch_debounce_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int TICK_CYCLES    = DEB_TICK_50MHZ_20MS,
  parameter int STABLE_SAMPLES = DEB_STABLE_SAMPLES
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic [WIDTH-1:0] iSwitch,
  input  logic             iAck,
  output logic [WIDTH-1:0] oSwitch,
  output logic [WIDTH-1:0] oEvent,
  output logic             oChanged,
  output logic             oTick
);

  localparam int               TICK_W    = clog2(TICK_CYCLES);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);

  logic [TICK_W-1:0] r_tick_cnt;
  logic              w_tick;

  assign w_tick = (r_tick_cnt == TICK_LAST);

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + TICK_W'(1);
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    switch_debounce_bit #(
      .STABLE_SAMPLES(STABLE_SAMPLES)
    ) u_bit (
      .iClk   (iClk),
      .iRst   (iRst),
      .i_raw  (iSwitch[g]),
      .i_tick (w_tick),
      .i_ack  (iAck),
      .o_level(oSwitch[g]),
      .o_event(oEvent[g])
    );
  end

  assign oTick    = w_tick;
  assign oChanged = |oEvent;

endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce with TICK_CYCLES=4, STABLE_SAMPLES=3.
module tb_switch_debounce;

  logic       iClk;
  logic       iRst;
  logic [7:0] iSwitch;
  logic       iAck;
  logic [7:0] oSwitch;
  logic [7:0] oEvent;
  logic       oChanged;
  logic       oTick;

  int total;
  int bad;
  int k;

  switch_debounce #(
    .WIDTH(8),
    .TICK_CYCLES(4),
    .STABLE_SAMPLES(3)
  ) dut (
    .iClk    (iClk),
    .iRst    (iRst),
    .iSwitch (iSwitch),
    .iAck    (iAck),
    .oSwitch (oSwitch),
    .oEvent  (oEvent),
    .oChanged(oChanged),
    .oTick   (oTick)
  );

  // clock / reset block
  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (k=%0d)", tag, got, exp, k);
    end
  endtask

  // One clock edge, then settle; k counts edges since the last reset release.
  task automatic step();
    @(posedge iClk);
    #1;
    k++;
  endtask

  task automatic run_to(input int target);
    while (k < target) step();
  endtask

  task automatic do_reset(input logic [7:0] sw);
    iSwitch = sw;
    iAck    = 1'b0;
    iRst    = 1'b1;
    #1;
    check("rst_async_sw", {24'd0, oSwitch}, 32'd0);
    step();
    step();
    check("rst_sw", {24'd0, oSwitch}, 32'd0);
    check("rst_ev", {24'd0, oEvent}, 32'd0);
    check("rst_chg", {31'd0, oChanged}, 32'd0);
    check("rst_tick", {31'd0, oTick}, 32'd0);
    iRst = 1'b0;
    k    = 0;
  endtask

  task automatic ack_pulse();
    iAck = 1'b1;
    step();
    iAck = 1'b0;
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    k       = 0;
    iRst    = 1'b1;
    iSwitch = 8'h00;
    iAck    = 1'b0;

    // Reset with all switches high: tick on every 4th cycle, commit on the 3rd tick (edge 12).
    do_reset(8'hFF);
    for (int j = 1; j <= 12; j++) begin
      step();
      check("tick_phase", {31'd0, oTick}, {31'd0, (j % 4) == 3});
      check("pwr_sw", {24'd0, oSwitch}, (j >= 12) ? 32'hFF : 32'h00);
    end
    check("pwr_ev", {24'd0, oEvent}, 32'hFF);
    check("pwr_chg", {31'd0, oChanged}, 32'd1);

    // Clean press: bit0 applied after edge 1, visible at edge 3, ticks 4/8/12.
    do_reset(8'h00);
    step();
    iSwitch = 8'h01;
    run_to(11);
    check("press_early", {24'd0, oSwitch}, 32'h00);
    step();
    check("press_sw", {24'd0, oSwitch}, 32'h01);
    check("press_ev", {24'd0, oEvent}, 32'h01);
    ack_pulse();
    check("ack_ev", {24'd0, oEvent}, 32'h00);
    check("ack_chg", {31'd0, oChanged}, 32'd0);

    // Bounce: bit1 high for ticks 16/20, low again by tick 24.
    iSwitch = 8'h03;
    run_to(21);
    iSwitch = 8'h01;
    run_to(24);
    check("bounce_sw", {24'd0, oSwitch}, 32'h01);
    check("bounce_ev", {24'd0, oEvent}, 32'h00);
    // Sustained high needs fresh ticks 28/32/36.
    step();
    iSwitch = 8'h03;
    run_to(35);
    check("resample_early", {24'd0, oSwitch}, 32'h01);
    step();
    check("resample_sw", {24'd0, oSwitch}, 32'h03);
    check("resample_ev", {24'd0, oEvent}, 32'h02);

    // Ack collision: bit0 falls (commit 48), bit2 rises (commit 52) with iAck high.
    ack_pulse();
    iSwitch = 8'h02;
    run_to(41);
    iSwitch = 8'h06;
    run_to(48);
    check("fall_sw", {24'd0, oSwitch}, 32'h02);
    check("fall_ev", {24'd0, oEvent}, 32'h01);
    run_to(51);
    ack_pulse();
    check("coll_sw", {24'd0, oSwitch}, 32'h06);
    check("coll_ev", {24'd0, oEvent}, 32'h04);
    check("coll_chg", {31'd0, oChanged}, 32'd1);

    // Reset mid-count: bit3 differs for ticks 56/60, then reset.
    ack_pulse();
    iSwitch = 8'h0E;
    run_to(61);
    do_reset(8'h0E);
    run_to(11);
    check("rmid_early", {24'd0, oSwitch}, 32'h00);
    check("rmid_early_ev", {24'd0, oEvent}, 32'h00);
    step();
    check("rmid_sw", {24'd0, oSwitch}, 32'h0E);
    check("rmid_ev", {24'd0, oEvent}, 32'h0E);

    // Multi-bit commit on one edge.
    do_reset(8'h00);
    step();
    iSwitch = 8'hA5;
    run_to(11);
    check("multi_early", {24'd0, oSwitch}, 32'h00);
    step();
    check("multi_sw", {24'd0, oSwitch}, 32'hA5);
    check("multi_ev", {24'd0, oEvent}, 32'hA5);
    check("multi_chg", {31'd0, oChanged}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
